// File: rtl/udm_resp_tx.sv
// UDM response transmitter: buffers 32-bit response words in a small FIFO and sends each
// one as four UART 8N1/8N2 frames (LSB byte first, LSB bit first) with no gaps between frames.
module udm_resp_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] bitperiod_i,
    input  logic [1:0]       stop_cfg_i,
    input  logic             word_vld_i,
    input  logic [31:0]      word_i,
    output logic             word_rdy_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy_q, rdy_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // Serialiser state
    state_e           state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic [DIV_W-1:0] pm1_q, pm1_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic             stop2_q, stop2_d;
    logic             stop_idx_q, stop_idx_d;
    logic [1:0]       byte_q, byte_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic [DIV_W-1:0] period_m1;
    logic [2:0]       bit_nxt;
    logic             load;

    assign push       = word_vld_i && rdy_q;
    assign fifo_empty = (count_q == '0);

    // Bit period minus one; a programmed period of 0 behaves as 1
    assign period_m1 = (bitperiod_i == '0) ? '0 : (bitperiod_i - DIV_W'(1));
    assign bit_nxt   = bit_q + 3'd1;

    // Next-state and serial output logic
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        pm1_d      = pm1_q;
        baud_d     = baud_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end

            ST_START: begin
                if (baud_q == '0) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = pm1_q;
                    tx_d    = word_q[{byte_q, 3'd0}];
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = pm1_q;
                    if (bit_q == 3'd7) begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = word_q[{byte_q, bit_nxt}];
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

            ST_STOP: begin
                if (baud_q == '0) begin
                    baud_d = pm1_q;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        tx_d       = 1'b1;
                    end else if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Fetch the next word; line settings are frozen for all four of its bytes
        if (load) begin
            word_d  = mem_q[rd_ptr_q];
            pm1_d   = period_m1;
            baud_d  = period_m1;
            stop2_d = (stop_cfg_i == 2'b01);
            byte_d  = 2'd0;
            bit_d   = 3'd0;
            state_d = ST_START;
            tx_d    = 1'b0;
        end
    end

    assign pop = load;

    // FIFO pointer/occupancy update, ready and busy flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        rdy_d  = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d = (count_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b1;
            state_q    <= ST_IDLE;
            word_q     <= '0;
            pm1_q      <= '0;
            baud_q     <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            byte_q     <= 2'd0;
            bit_q      <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            state_q    <= state_d;
            word_q     <= word_d;
            pm1_q      <= pm1_d;
            baud_q     <= baud_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign word_rdy_o = rdy_q;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;

endmodule
